lac_block_accumulator: RTL

Downstream consumer of the 4-bit lookahead-carry counter: accepts a stream of 4-bit samples over a valid/ready handshake, sums a block of `NSAMP` samples into an 8-bit register, and presents the block total over a second valid/ack handshake. The 8-bit add is built from two chained 4-bit lookahead-carry adder slices: the low-nibble carry-out feeds the high-nibble carry-in. A sticky overflow flag is set by the high-slice carry-out.

---
 rtl/lac_block_accumulator.sv | 124 ++++++++++++
 1 files changed

// File: rtl/lac_block_accumulator.sv
// Block accumulator: sums NSAMP 4-bit samples into an 8-bit total built from two
// chained 4-bit lookahead-carry slices, with a sticky overflow from the high slice.

module lac_cla4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] s,
   output logic       cout
);
   logic [3:0] g;
   logic [3:0] p;
   logic [4:0] c;

   assign g = a & b;
   assign p = a ^ b;

   // All carries are flattened sums of products so none ripples through another.
   assign c[0] = cin;
   assign c[1] = g[0] | (p[0] & c[0]);
   assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
   assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
   assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
               | (p[3] & p[2] & p[1] & p[0] & c[0]);

   assign s    = p ^ c[3:0];
   assign cout = c[4];
endmodule

module lac_block_accumulator #(
   parameter int NSAMP = 8
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] din,
   input  logic       din_valid,
   output logic       din_ready,
   output logic [7:0] sum,
   output logic       ovf,
   output logic       sum_valid,
   input  logic       sum_ack,
   output logic       busy,
   output logic [1:0] state_dbg,
   output logic [7:0] count_dbg
);
   // Handshakes: a sample transfers on any rising edge with din_valid & din_ready;
   // the total transfers on the edge where sum_valid & sum_ack are both high.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [7:0] LAST = 8'(NSAMP - 1);

   state_t     state;
   state_t     state_next;
   logic       clr;
   logic       take;
   logic [7:0] count;
   logic [3:0] s_lo;
   logic [3:0] s_hi;
   logic       c_lo;
   logic       c_hi;

   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      clr        = 1'b0;
      take       = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               clr        = 1'b1;
               state_next = S_ACC;
            end
         end
         S_ACC: begin
            if (din_valid) begin
               take = 1'b1;
               if (count == LAST) state_next = S_DONE;
            end
         end
         S_DONE: begin
            if (sum_ack) begin
               if (start) begin
                  clr        = 1'b1;
                  state_next = S_ACC;
               end else begin
                  state_next = S_IDLE;
               end
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Low-slice carry-out drives the high-slice carry-in; the high slice only adds zero.
   lac_cla4 u_lo (.a(sum[3:0]), .b(din),     .cin(1'b0), .s(s_lo), .cout(c_lo));
   lac_cla4 u_hi (.a(sum[7:4]), .b(4'b0000), .cin(c_lo), .s(s_hi), .cout(c_hi));

   always_ff @(posedge clock) begin
      if (reset || clr) begin
         sum   <= 8'h00;
         ovf   <= 1'b0;
         count <= 8'h00;
      end else if (take) begin
         sum   <= {s_hi, s_lo};
         ovf   <= ovf | c_hi;
         count <= count + 8'd1;
      end
   end

   assign din_ready = (state == S_ACC);
   assign sum_valid = (state == S_DONE);
   assign busy      = (state != S_IDLE);
   assign state_dbg = state;
   assign count_dbg = count;
endmodule
